seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Parametrised time-multiplexed seven-segment driver. It is the successor to the fixed two-digit health display.
- Scans NUM_DIGITS hex digits at a programmable slot rate.
- Provides per-digit blanking, decimal points and blinking (used for low-health warning).
- Inserts a ghosting guard at each slot change.
- Sits between game-state logic (health, score, timer nibbles) and the board's SEG_SEL/SEG_DATA pins.

Parameters:
NUM_DIGITS, 5, number of scanned digits; width of SEG_SEL
SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
GUARD_CYCLES, 2, cycles at slot start with SEG_SEL forced 0 (0 <= GUARD_CYCLES < SCAN_DIV)
BLINK_DIV, 64, full scan frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
digit_vals  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k]
digit_en  in  NUM_DIGITS  1 = digit shown, 0 = blanked
blink_mask  in  NUM_DIGITS  1 = digit blanked during blink phase 1
dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit k
SEG_SEL  out  NUM_DIGITS  one-hot digit select, active-high, registered
SEG_DATA  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered
frame_tick  out  1  one-cycle pulse when slot 0 is loaded

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.

Reset:
- div_cnt=0, slot=NUM_DIGITS-1, frame_cnt=0, blink_phase=0.
- SEG_SEL=0, SEG_DATA=0, frame_tick=0.
- Reset wins over all other activity, including mid-slot.
- The first slot period after reset is dark. Digit 0 is loaded at the SCAN_DIV-th rising edge after rst falls.

Prescaler:
- div_cnt counts 0..SCAN_DIV-1 every cycle, then wraps to 0.
- The edge where div_cnt==SCAN_DIV-1 is the "load edge": slot <= (slot==NUM_DIGITS-1) ? 0 : slot+1.

Load edge, new slot k:
- Inputs are sampled only at this edge and held for the whole slot. Input changes mid-slot have no visible effect.
- visible = digit_en[k] & ~(blink_mask[k] & phase), where phase is the blink phase after any update on this same edge.
- SEG_DATA <= visible ? {dp_mask[k], enc(nibble k)} : 8'h00.
- SEG_SEL <= (visible && GUARD_CYCLES==0) ? onehot(k) : 0.

Guard release:
- On the edge where div_cnt becomes GUARD_CYCLES (GUARD_CYCLES>0), SEG_SEL <= visible ? onehot(k) : 0.
- SEG_SEL is never multi-hot. It is 0 during the guard and for blanked slots.
- Blanked slots keep their time slot, so scan duty per digit is constant.

Encoding, enc(0..F), as {g..a}:
- 0 3F, 1 06, 2 5B, 3 4F
- 4 66, 5 6D, 6 7D, 7 07
- 8 7F, 9 6F, A 77, b 7C
- C 39, d 5E, E 79, F 71

Frame and blink:
- On each load edge into slot 0, frame_tick <= 1 for exactly one cycle; otherwise frame_tick=0.
- On the same edge: if frame_cnt==BLINK_DIV-1, then frame_cnt <= 0 and blink_phase toggles; else frame_cnt++.
- The toggled phase applies to the entire frame starting at that edge, slot 0 included.
- With BLINK_DIV=1, blink_phase toggles every frame.

Width rules:
- div_cnt is clog2(SCAN_DIV) bits; slot is clog2(NUM_DIGITS) bits; frame_cnt is clog2(BLINK_DIV) bits. Each has at least 1 bit.
- All compares are unsigned. No counter value exceeds its terminal count.

Test Plan:
Bench parameters: NUM_DIGITS=5, SCAN_DIV=4, GUARD_CYCLES=1, BLINK_DIV=2. All inputs 0 except as stated.

1. Reset and first scan: assert rst 3 cycles, digit_vals=0x43210, digit_en=5'h1F.
   -> SEG_SEL=0 and SEG_DATA=0 for cycles 0-3 after release.
   -> Load edge 4: SEG_DATA=3F, SEG_SEL=0 for one cycle, then 00001 for 3 cycles.
   -> Digit 1: 06/00010; digit 2: 5B/00100; digit 3: 4F/01000; digit 4: 66/10000.
   -> frame_tick high exactly one cycle at each slot-0 load (every 20 cycles).
2. Encoding sweep: step digit 0 through 0..F, one value per frame.
   -> SEG_DATA in slot 0 matches the table: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
3. Blanking and dp: digit_en=5'b10101, dp_mask=5'b00100.
   -> Slots 1 and 3 have SEG_SEL=0 and SEG_DATA=00.
   -> Slot 2 has SEG_DATA bit7=1.
   -> Frame period stays 20 cycles.
4. Blink: blink_mask=5'b00001, digit 0 value 3.
   -> Slot 0 shows 4F in frames 1-2, is dark in frames 3-4, shows 4F again in frames 5-6.
   -> Other digits are unaffected.
5. Mid-slot input change: change digit_vals for the current slot at div_cnt=2.
   -> SEG_DATA holds the old value until that digit's next load edge.
6. Reset mid-operation: assert rst in slot 3 at div_cnt=2.
   -> The next cycle shows SEG_SEL=0, SEG_DATA=0, frame_tick=0.
   -> After release, the sequence exactly repeats scenario 1 timing, with blink phase restarted at 0.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: one digit per slot, with a dark guard
// at each slot start, per-digit blanking, decimal points and frame-based blinking.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 5,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_DIV    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digit_vals,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [NUM_DIGITS-1:0]     SEG_SEL,
  output logic [7:0]                SEG_DATA,
  output logic                      frame_tick
);

  localparam int DIV_W   = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]   GUARD_V    = DIV_W'(GUARD_CYCLES);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  function automatic logic [6:0] enc7(input logic [3:0] n);
    case (n)
      4'h0: enc7 = 7'h3F;  4'h1: enc7 = 7'h06;  4'h2: enc7 = 7'h5B;  4'h3: enc7 = 7'h4F;
      4'h4: enc7 = 7'h66;  4'h5: enc7 = 7'h6D;  4'h6: enc7 = 7'h7D;  4'h7: enc7 = 7'h07;
      4'h8: enc7 = 7'h7F;  4'h9: enc7 = 7'h6F;  4'hA: enc7 = 7'h77;  4'hB: enc7 = 7'h7C;
      4'hC: enc7 = 7'h39;  4'hD: enc7 = 7'h5E;  4'hE: enc7 = 7'h79;  default: enc7 = 7'h71;
    endcase
  endfunction

  logic [DIV_W-1:0]      div_q, div_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic                  vis_q, vis_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            data_q, data_d;
  logic                  tick_q, tick_d;

  logic                  load;
  logic [3:0]            nib;
  logic                  en_k, blink_k, dp_k, vis_new;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    load   = (div_q == DIV_LAST);
    div_d  = load ? '0 : div_q + 1'b1;
    slot_d = slot_q;
    if (load) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

    // Blink phase advances on the slot-0 load so the whole new frame sees it.
    frame_d = frame_q;
    phase_d = phase_q;
    tick_d  = load && (slot_d == '0);
    if (tick_d) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    nib     = '0;
    en_k    = 1'b0;
    blink_k = 1'b0;
    dp_k    = 1'b0;
    onehot  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_d == SLOT_W'(k)) begin
        nib       = digit_vals[4*k +: 4];
        en_k      = digit_en[k];
        blink_k   = blink_mask[k];
        dp_k      = dp_mask[k];
        onehot[k] = 1'b1;
      end
    end
    vis_new = en_k & ~(blink_k & phase_d);

    // Inputs are captured only at the load edge; visibility is held for the guard release.
    vis_d  = vis_q;
    sel_d  = sel_q;
    data_d = data_q;
    if (load) begin
      vis_d  = vis_new;
      data_d = vis_new ? {dp_k, enc7(nib)} : 8'h00;
      sel_d  = (vis_new && GUARD_CYCLES == 0) ? onehot : '0;
    end else if (GUARD_CYCLES > 0 && div_d == GUARD_V) begin
      sel_d = vis_q ? onehot : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      slot_q  <= SLOT_LAST;
      frame_q <= '0;
      phase_q <= 1'b0;
      vis_q   <= 1'b0;
      sel_q   <= '0;
      data_q  <= 8'h00;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      vis_q   <= vis_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
    end
  end

  assign SEG_SEL    = sel_q;
  assign SEG_DATA   = data_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: time-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_seg_scan_mux;

  localparam int ND = 5;
  localparam int SD = 4;
  localparam int GC = 1;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [19:0]   digit_vals = '0;
  logic [ND-1:0] digit_en   = '0;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] dp_mask    = '0;
  logic [ND-1:0] SEG_SEL;
  logic [7:0]    SEG_DATA;
  logic          frame_tick;

  seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYCLES(GC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .digit_vals(digit_vals), .digit_en(digit_en),
    .blink_mask(blink_mask), .dp_mask(dp_mask),
    .SEG_SEL(SEG_SEL), .SEG_DATA(SEG_DATA), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: position in the scan is derived purely from edges since reset release.
  int         m_t = 0;
  int         u, s, p, f, ph;
  logic       m_vis = 1'b0;
  logic [4:0] e_sel = '0;
  logic [7:0] e_data = '0;
  logic       e_tick = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_vis = 1'b0; e_sel = '0; e_data = '0; e_tick = 1'b0;
    end else begin
      m_t++;
      e_tick = 1'b0;
      if (m_t >= SD) begin
        u  = m_t - SD;
        s  = (u / SD) % ND;
        p  = u % SD;
        f  = u / (SD * ND);
        ph = ((f + 1) / BD) % 2;
        if (p == 0) begin
          m_vis  = digit_en[s] && !(blink_mask[s] && ph == 1);
          e_data = m_vis ? {dp_mask[s], ENC[digit_vals[4*s +: 4]]} : 8'h00;
          e_sel  = (m_vis && GC == 0) ? (5'b1 << s) : '0;
          e_tick = (s == 0);
        end else if (p == GC) begin
          e_sel = m_vis ? (5'b1 << s) : '0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_sel",  32'(SEG_SEL),    32'(e_sel));
      chk("model_data", 32'(SEG_DATA),   32'(e_data));
      chk("model_tick", 32'(frame_tick), 32'(e_tick));
    end
  end

  function automatic int t_of(input int fr, input int sl, input int ps);
    return SD + (fr * ND + sl) * SD + ps;
  endfunction

  task automatic goto(input int tt);
    int n = 0;
    while (m_t != tt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (m_t != tt) begin
      checks++;
      errors++;
      $display("FAIL goto: reached t=%0d expected t=%0d", m_t, tt);
    end
  endtask

  initial begin
    // Scenario 1: reset and first scan
    digit_vals = 20'h43210;
    digit_en   = 5'h1F;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    goto(3);  chk("s1_dark_sel", 32'(SEG_SEL), 0); chk("s1_dark_data", 32'(SEG_DATA), 0);
    goto(4);  chk("s1_d0_data", 32'(SEG_DATA), 32'h3F); chk("s1_d0_guard", 32'(SEG_SEL), 0);
              chk("s1_tick", 32'(frame_tick), 1);
    goto(5);  chk("s1_d0_sel", 32'(SEG_SEL), 32'h01); chk("s1_tick_off", 32'(frame_tick), 0);
    goto(8);  chk("s1_d1_data", 32'(SEG_DATA), 32'h06); chk("s1_d1_guard", 32'(SEG_SEL), 0);
    goto(9);  chk("s1_d1_sel", 32'(SEG_SEL), 32'h02);
    goto(13); chk("s1_d2", 32'(SEG_DATA), 32'h5B); chk("s1_d2_sel", 32'(SEG_SEL), 32'h04);
    goto(17); chk("s1_d3", 32'(SEG_DATA), 32'h4F); chk("s1_d3_sel", 32'(SEG_SEL), 32'h08);
    goto(21); chk("s1_d4", 32'(SEG_DATA), 32'h66); chk("s1_d4_sel", 32'(SEG_SEL), 32'h10);
    goto(24); chk("s1_tick2", 32'(frame_tick), 1); chk("s1_f1_data", 32'(SEG_DATA), 32'h3F);

    // Scenario 2: encoding sweep on digit 0, one value per frame
    for (int v = 0; v < 16; v++) begin
      goto(t_of(v + 1, 2, 0));
      digit_vals[3:0] = 4'(v);
      goto(t_of(v + 2, 0, 0));
      if (v == 2)  chk("s2_enc2", 32'(SEG_DATA), 32'h5B);
      if (v == 11) chk("s2_encb", 32'(SEG_DATA), 32'h7C);
      if (v == 15) chk("s2_encF", 32'(SEG_DATA), 32'h71);
    end

    // Scenario 3: blanking and decimal point
    goto(t_of(17, 2, 0));
    digit_en = 5'b10101;
    dp_mask  = 5'b00100;
    goto(t_of(18, 1, 3)); chk("s3_blank1_sel", 32'(SEG_SEL), 0); chk("s3_blank1_data", 32'(SEG_DATA), 0);
    goto(t_of(18, 2, 0)); chk("s3_dp_data", 32'(SEG_DATA), 32'hDB);
    goto(t_of(18, 2, 1)); chk("s3_d2_sel", 32'(SEG_SEL), 32'h04);
    goto(t_of(18, 3, 2)); chk("s3_blank3_sel", 32'(SEG_SEL), 0); chk("s3_blank3_data", 32'(SEG_DATA), 0);
    goto(t_of(19, 0, 0)); chk("s3_period", 32'(frame_tick), 1);

    // Scenario 4: blink on digit 0
    goto(t_of(19, 2, 0));
    digit_en        = 5'h1F;
    dp_mask         = 5'h00;
    blink_mask      = 5'b00001;
    digit_vals[3:0] = 4'h3;
    goto(t_of(20, 0, 1)); chk("s4_on_data", 32'(SEG_DATA), 32'h4F); chk("s4_on_sel", 32'(SEG_SEL), 32'h01);
    goto(t_of(21, 0, 1)); chk("s4_off_data", 32'(SEG_DATA), 0); chk("s4_off_sel", 32'(SEG_SEL), 0);
    goto(t_of(21, 1, 1)); chk("s4_d1_data", 32'(SEG_DATA), 32'h06); chk("s4_d1_sel", 32'(SEG_SEL), 32'h02);
    goto(t_of(22, 0, 2)); chk("s4_off2_data", 32'(SEG_DATA), 0);
    goto(t_of(23, 0, 1)); chk("s4_on2_data", 32'(SEG_DATA), 32'h4F); chk("s4_on2_sel", 32'(SEG_SEL), 32'h01);

    // Scenario 5: mid-slot input change is ignored until the next load
    goto(t_of(24, 1, 2));
    digit_vals[7:4] = 4'h9;
    goto(t_of(24, 1, 3)); chk("s5_hold", 32'(SEG_DATA), 32'h06);
    goto(t_of(25, 1, 0)); chk("s5_new", 32'(SEG_DATA), 32'h6F);
    goto(t_of(25, 1, 1)); chk("s5_sel", 32'(SEG_SEL), 32'h02);

    // Scenario 6: reset mid-slot, then scan restarts with blink phase 0
    goto(t_of(25, 3, 2));
    rst        = 1'b1;
    digit_vals = 20'h43210;
    @(negedge clk);
    chk("s6_rst_sel", 32'(SEG_SEL), 0);
    chk("s6_rst_data", 32'(SEG_DATA), 0);
    chk("s6_rst_tick", 32'(frame_tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    goto(3);  chk("s6_dark_data", 32'(SEG_DATA), 0); chk("s6_dark_sel", 32'(SEG_SEL), 0);
    goto(4);  chk("s6_d0_data", 32'(SEG_DATA), 32'h3F); chk("s6_tick", 32'(frame_tick), 1);
    goto(5);  chk("s6_d0_sel", 32'(SEG_SEL), 32'h01);
    goto(t_of(1, 0, 1)); chk("s6_blink_off", 32'(SEG_DATA), 0); chk("s6_blink_sel", 32'(SEG_SEL), 0);
    goto(t_of(1, 1, 1)); chk("s6_d1_data", 32'(SEG_DATA), 32'h06); chk("s6_d1_sel", 32'(SEG_SEL), 32'h02);
    goto(t_of(3, 0, 1)); chk("s6_blink_on", 32'(SEG_DATA), 32'h3F); chk("s6_on_sel", 32'(SEG_SEL), 32'h01);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
